// File: rtl/filtro_down.sv
// rtl/filtro_down.sv - 7-tap FIR interpolation filter for the 3/4 sub-pixel position
//
// Purpose:
//   Takes seven signed neighbouring samples in parallel.
//   Applies the fixed coefficient set +1, -5, +17, +58, -10, +4, -1 (gain 64).
//   Rounds half-up, saturates to the sample range and registers the result.
//   Latency is one clock. This is the mirror of the 1/4-position ("up") filter.
//
// Ports:
//   clock       rising-edge clock
//   reset       synchronous, active-high; clears out, has priority over enable
//   enable      captures a new result at the rising edge when high
//   in0..in6    DATA_WIDTH+2 bit signed taps, in0 oldest/leftmost, in6 newest/rightmost
//   out         DATA_WIDTH+2 bit signed registered filtered sample

module filtro_down #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic signed [DATA_WIDTH+1:0] in0,
    input  logic signed [DATA_WIDTH+1:0] in1,
    input  logic signed [DATA_WIDTH+1:0] in2,
    input  logic signed [DATA_WIDTH+1:0] in3,
    input  logic signed [DATA_WIDTH+1:0] in4,
    input  logic signed [DATA_WIDTH+1:0] in5,
    input  logic signed [DATA_WIDTH+1:0] in6,
    output logic signed [DATA_WIDTH+1:0] out
);

    localparam int SW = DATA_WIDTH + 2;
    localparam int AW = DATA_WIDTH + 10;

    localparam logic signed [AW-1:0] ROUND = AW'(32);
    localparam logic signed [AW-1:0] MAXV  = AW'((64'sd1 <<< (DATA_WIDTH + 1)) - 64'sd1);
    localparam logic signed [AW-1:0] MINV  = AW'(-(64'sd1 <<< (DATA_WIDTH + 1)));

    // Taps sign-extended to accumulator width before any shifting.
    // The worst-case sum (|x| * 96) then fits without overflow.
    logic signed [AW-1:0] x0, x1, x2, x3, x4, x5, x6;
    logic signed [AW-1:0] p1, p2, p3, p4, p5;
    logic signed [AW-1:0] sum;
    logic signed [AW-1:0] acc_r;
    logic signed [SW-1:0] sat;

    assign x0 = {{(AW-SW){in0[SW-1]}}, in0};
    assign x1 = {{(AW-SW){in1[SW-1]}}, in1};
    assign x2 = {{(AW-SW){in2[SW-1]}}, in2};
    assign x3 = {{(AW-SW){in3[SW-1]}}, in3};
    assign x4 = {{(AW-SW){in4[SW-1]}}, in4};
    assign x5 = {{(AW-SW){in5[SW-1]}}, in5};
    assign x6 = {{(AW-SW){in6[SW-1]}}, in6};

    // Shift-and-add products (magnitudes; signs are applied in the sum).
    assign p1 = (x1 <<< 2) + x1;                  //  5 = 4 + 1
    assign p2 = (x2 <<< 4) + x2;                  // 17 = 16 + 1
    assign p3 = (x3 <<< 6) - (x3 <<< 2) - (x3 <<< 1); // 58 = 64 - 4 - 2
    assign p4 = (x4 <<< 3) + (x4 <<< 1);          // 10 = 8 + 2
    assign p5 = x5 <<< 2;                         //  4

    assign sum = x0 - p1 + p2 + p3 - p4 + p5 - x6;

    // The arithmetic shift floors, so adding half an LSB first yields round-half-up,
    // including for negative sums.
    assign acc_r = (sum + ROUND) >>> 6;

    always_comb begin
        sat = acc_r[SW-1:0];
        if (acc_r > MAXV) begin
            sat = MAXV[SW-1:0];
        end else if (acc_r < MINV) begin
            sat = MINV[SW-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out <= '0;
        end else if (enable) begin
            out <= sat;
        end
    end

endmodule

// File: tb/tb_filtro_down.sv
// tb/tb_filtro_down.sv - scoreboard testbench for filtro_down

module tb_filtro_down;

    localparam int DATA_WIDTH = 8;
    localparam int SW = DATA_WIDTH + 2;

    logic                 clock;
    logic                 reset;
    logic                 enable;
    logic signed [SW-1:0] in0, in1, in2, in3, in4, in5, in6;
    logic signed [SW-1:0] out;

    typedef struct {
        string name;
        int    exp;
    } exp_t;

    exp_t expq[$];
    int   checks   = 0;
    int   failures = 0;

    filtro_down #(.DATA_WIDTH(DATA_WIDTH)) dut (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .in0    (in0),
        .in1    (in1),
        .in2    (in2),
        .in3    (in3),
        .in4    (in4),
        .in5    (in5),
        .in6    (in6),
        .out    (out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One scoreboard entry per clock edge driven. The entry is pushed half a cycle
    // before the edge that should produce it.
    task automatic step(input string name, input bit rst, input bit en, input bit xin,
                        input int a, input int b, input int c, input int d,
                        input int e, input int f, input int g, input int exp);
        exp_t t;
        @(negedge clock);
        reset  = rst;
        enable = en;
        if (xin) begin
            in0 = 'x; in1 = 'x; in2 = 'x; in3 = 'x; in4 = 'x; in5 = 'x; in6 = 'x;
        end else begin
            in0 = SW'(a); in1 = SW'(b); in2 = SW'(c); in3 = SW'(d);
            in4 = SW'(e); in5 = SW'(f); in6 = SW'(g);
        end
        t.name = name;
        t.exp  = exp;
        expq.push_back(t);
    endtask

    // Monitor: after every edge for which an expectation is queued, compare out.
    always @(posedge clock) begin
        if (expq.size() > 0) begin
            exp_t t;
            #1;
            t = expq.pop_front();
            checks++;
            if (int'(out) != t.exp) begin
                failures++;
                $display("FAIL %s: out=%0d expected=%0d", t.name, int'(out), t.exp);
            end
        end
    end

    initial begin
        int waited;
        reset  = 1'b1;
        enable = 1'b0;
        in0 = '0; in1 = '0; in2 = '0; in3 = '0; in4 = '0; in5 = '0; in6 = '0;

        step("reset_idle",   1, 0, 0,   0,   0,   0,   0,   0,   0,   0,    0);
        step("reset_en",     1, 1, 0, 121,   5, 213,  50,  30, 184,   6,    0);
        step("idle_after",   0, 0, 0, 121,   5, 213,  50,  30, 184,   6,    0);
        step("vec1",         0, 1, 0, 121,   5, 213,  50,  30, 184,   6,  110);
        step("hold_new_in",  0, 0, 0, 100, 100, 100, 100, 100, 100, 100,  110);
        step("hold_x_in",    0, 0, 1,   0,   0,   0,   0,   0,   0,   0,  110);
        step("reset_prio",   1, 1, 0, 100, 100, 100, 100, 100, 100, 100,    0);
        step("after_reset",  0, 1, 0, 100, 100, 100, 100, 100, 100, 100,  100);
        step("all_zero",     0, 1, 0,   0,   0,   0,   0,   0,   0,   0,    0);
        step("all_m1",       0, 1, 0,  -1,  -1,  -1,  -1,  -1,  -1,  -1,   -1);
        step("pos_sat",      0, 1, 0, 511,-512, 511, 511,-512, 511,-512,  511);
        step("hold_pos",     0, 0, 0,   0,   0,   0,   0,   0,   0,   0,  511);
        step("neg_sat",      0, 1, 0,-512, 511,-512,-512, 511,-512, 511, -512);
        step("all_max",      0, 1, 0, 511, 511, 511, 511, 511, 511, 511,  511);
        step("all_min",      0, 1, 0,-512,-512,-512,-512,-512,-512,-512, -512);
        step("half_pos",     0, 1, 0,  32,   0,   0,   0,   0,   0,   0,    1);
        step("below_half",   0, 1, 0,  31,   0,   0,   0,   0,   0,   0,    0);
        step("half_neg",     0, 1, 0, -32,   0,   0,   0,   0,   0,   0,    0);
        step("below_hneg",   0, 1, 0, -33,   0,   0,   0,   0,   0,   0,   -1);
        step("tap3_only",    0, 1, 0,   0,   0,   0,   8,   0,   0,   0,    7);
        step("tap4_only",    0, 1, 0,   0,   0,   0,   0,  64,   0,   0,  -10);

        waited = 0;
        while (expq.size() > 0 && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        if (expq.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: pending=%0d expected=0", expq.size());
        end
        @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
